// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and EX forwarding control
// Optional HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic              load_use, lu_stall;
    logic [1:0]        fwd_a_next, fwd_b_next;

    logic              ex_valid, ex_regwrite, ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid, mem_regwrite;
    logic [REG_AW-1:0] mem_rd;

    // x0 is hardwired to zero, so it never takes part in a dependency
    function automatic logic dep(input logic v, input logic rw,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] rs);
        return v && rw && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
        input logic ev, input logic erw, input logic emr, input logic [REG_AW-1:0] erd,
        input logic mv, input logic mrw, input logic [REG_AW-1:0] mrd);
        if (dep(ev, erw, erd, rs) && !emr)
            return 2'b10;
        else if (dep(mv, mrw, mrd, rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = id_valid && ex_memread &&
                      ((id_use_rs1 && dep(ex_valid, ex_regwrite, ex_rd, id_rs1)) ||
                       (id_use_rs2 && dep(ex_valid, ex_regwrite, ex_rd, id_rs2)));

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        lu_stall    = 1'b0;
        if (ex_branch_taken) begin
            // a taken branch wins over everything, including a pending load-use
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_next    = FLUSH_LOAD;
            state_next  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (state)
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_next    = cnt - 2'd1;
                    state_next  = (cnt <= 2'd1) ? RUN : FLUSH;
                end
                default: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        lu_stall    = 1'b1;
                        state_next  = LU_STALL;
                    end else begin
                        state_next  = RUN;
                    end
                end
            endcase
        end
    end

    assign fwd_a_next = fwd_sel(id_rs1, ex_valid, ex_regwrite, ex_memread, ex_rd,
                                mem_valid, mem_regwrite, mem_rd);
    assign fwd_b_next = fwd_sel(id_rs2, ex_valid, ex_regwrite, ex_memread, ex_rd,
                                mem_valid, mem_regwrite, mem_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            cnt          <= 2'd0;
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            fwd_a        <= 2'b00;
            fwd_b        <= 2'b00;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (idex_bubble || !id_valid) begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_rd       <= id_rd;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
            end
            fwd_a <= idex_bubble ? 2'b00 : fwd_a_next;
            fwd_b <= idex_bubble ? 2'b00 : fwd_b_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (lu_stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (ifid_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = lu_stall;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // exp packs {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b}
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, br;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         compared = 0;
    int         mismatched = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic br,
                                input logic [7:0] exp);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.mr = mr; r.br = br; r.exp = exp;
        return r;
    endfunction

    task automatic apply_inputs(input vec_t r);
        id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_use_rs1 = r.u1; id_use_rs2 = r.u2;
        id_rd = r.rd; id_regwrite = r.rw; id_memread = r.mr; ex_branch_taken = r.br;
    endtask

    task automatic check_out(input string name);
        logic [7:0] act, exp;
        act = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b};
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL %s: scoreboard empty, actual %b", name, act);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                mismatched++;
                $display("FAIL %s: actual {pc,ifid_w,flush,bubble,fa,fb}=%b required %b", name, act, exp);
            end
        end
    endtask

    task automatic step(input vec_t r, input string name);
        @(negedge clk);
        apply_inputs(r);
        sb.push_back(r.exp);
        #2;
        check_out(name);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000);
        // reset and idle
        vecs.push_back(idle); vecs.push_back(idle); vecs.push_back(idle);
        // add x5 ; sub x6,x5,x5 -> EX/MEM forward
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_1010));
        // add x8 ; unrelated ; use x8 -> MEM/WB forward
        vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 1, 2, 1, 1, 9, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 8, 8, 1, 1, 10, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0101));
        // lw x7 ; add rs2=x7 -> one stall, then fwd_b=01
        vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 3, 7, 1, 1, 11, 1, 0, 0, 8'b0001_0000));
        vecs.push_back(mk(1, 3, 7, 1, 1, 11, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0001));
        // lw x0 ; use x0 -> no stall, no forward
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 0, 0, 1, 1, 12, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000));
        // lw x7 ; use x7 with branch taken -> flush wins, 2 flush cycles
        vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 3, 7, 1, 1, 13, 1, 0, 1, 8'b1111_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0000));
        vecs.push_back(idle);
        // same rd in EX and MEM -> EX wins
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(1, 4, 4, 1, 1, 14, 1, 0, 0, 8'b1100_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_1010));
        // branch, branch again inside FLUSH reloads the counter
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1111_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1111_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0000));
        vecs.push_back(idle);

        apply_inputs(idle);
        reset_n = 1'b0;
        #2;
        sb.push_back(8'b1100_0000);
        check_out("in_reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, 32'd1);
        check_val("flush_cnt", flush_cnt, 32'd5);
`endif

        // reset in the middle of a reloaded flush abandons it at once
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1111_0000), "rst_br");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1111_0000), "rst_flush");
        #1;
        reset_n = 1'b0;
        apply_inputs(idle);
        #1;
        sb.push_back(8'b1100_0000);
        check_out("rst_async");
`ifdef HAZARD_PERF_CNT_EN
        check_val("rst_stall_cnt", stall_cnt, 32'd0);
        check_val("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step(idle, "post_rst0");
        step(idle, "post_rst1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
